// File: rtl/riscv_i32_ifetch_mem_adapter.sv
// Instruction-fetch adapter: turns ifetch requests into single-word SRAM reads and returns tagged responses.
// The read strobe is driven in the accept cycle; every ifetch_resp__* field is registered.
module riscv_i32_ifetch_mem_adapter #(
  parameter logic [31:0] MEM_BASE      = 32'h0000_0000,
  parameter int          MEM_SIZE_LOG2 = 16,
  parameter int          WAIT_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifetch_req__flush_pipeline,
  input  logic [2:0]  ifetch_req__req_type,
  input  logic        ifetch_req__debug_fetch,
  input  logic [31:0] ifetch_req__address,
  input  logic [2:0]  ifetch_req__mode,
  input  logic        ifetch_req__predicted_branch,
  input  logic [31:0] ifetch_req__pc_if_mispredicted,
  output logic        ifetch_resp__valid,
  output logic        ifetch_resp__debug,
  output logic [31:0] ifetch_resp__data,
  output logic [2:0]  ifetch_resp__mode,
  output logic        ifetch_resp__error,
  output logic [1:0]  ifetch_resp__tag,
  output logic        mem_read_enable,
  output logic [29:0] mem_address,
  input  logic [31:0] mem_read_data,
  input  logic        mem_wait,
  input  logic        mem_error
);

  typedef enum logic [1:0] {IDLE, ACCESS, LOCAL} state_e;

  state_e      state_q;
  logic [1:0]  tag_q;
  logic [7:0]  wait_cnt_q;
  logic        drain_q;
  logic        pend_q;
  logic [29:0] addr_q;
  logic [2:0]  mode_q;
  logic [1:0]  rtag_q;

  logic        resp_valid_q;
  logic        resp_debug_q;
  logic [31:0] resp_data_q;
  logic [2:0]  resp_mode_q;
  logic        resp_error_q;
  logic [1:0]  resp_tag_q;

  logic        req_vld;
  logic        flush;
  logic        in_access;
  logic        accept;
  logic [1:0]  req_tag;
  logic [31:0] offset;
  logic        fault;
  logic        req_mem;
  logic        issued_active;
  logic        outstanding;
  logic        issue_new;
  logic        issue_pend;
  logic        wait_hit;
  logic        data_done;
  logic        timeout;
  logic        unused_ok;

  assign unused_ok = ^{ifetch_req__predicted_branch, ifetch_req__pc_if_mispredicted};

  assign req_vld   = |ifetch_req__req_type;
  assign flush     = ifetch_req__flush_pipeline;
  assign in_access = (state_q == ACCESS);
  assign accept    = (req_vld || flush) && (!in_access || flush);
  assign req_tag   = tag_q + {1'b0, flush};

  assign offset  = ifetch_req__address - MEM_BASE;
  assign fault   = !ifetch_req__debug_fetch &&
                   ((ifetch_req__address[1:0] != 2'b00) || ((offset >> MEM_SIZE_LOG2) != 32'd0));
  assign req_mem = req_vld && !ifetch_req__debug_fetch && !fault;

  // A read is still owned by memory if it was abandoned, or is the live access already issued.
  assign issued_active = in_access && !pend_q;
  assign outstanding   = drain_q || issued_active;
  assign issue_new     = accept && req_mem && !outstanding;
  assign issue_pend    = in_access && pend_q && !drain_q && !accept;

  assign wait_hit  = (wait_cnt_q + 8'd1) >= 8'(WAIT_TIMEOUT);
  assign data_done = issued_active && !mem_wait;
  assign timeout   = in_access && mem_wait && wait_hit;

  always_comb begin
    mem_read_enable = 1'b0;
    mem_address     = '0;
    if (!reset) begin
      if (issue_new) begin
        mem_read_enable = 1'b1;
        mem_address     = ifetch_req__address[31:2];
      end else if (issue_pend) begin
        mem_read_enable = 1'b1;
        mem_address     = addr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      wait_cnt_q   <= '0;
      drain_q      <= 1'b0;
      pend_q       <= 1'b0;
      addr_q       <= '0;
      mode_q       <= '0;
      rtag_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_debug_q <= 1'b0;
      resp_data_q  <= '0;
      resp_mode_q  <= '0;
      resp_error_q <= 1'b0;
      resp_tag_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_debug_q <= 1'b0;
      resp_data_q  <= '0;
      resp_mode_q  <= '0;
      resp_error_q <= 1'b0;
      resp_tag_q   <= '0;

      if (in_access && mem_wait) wait_cnt_q <= wait_cnt_q + 8'd1;
      if (issue_pend) begin
        pend_q     <= 1'b0;
        wait_cnt_q <= '0;
      end

      // An abandoned read keeps draining until memory signals completion once.
      drain_q <= mem_wait && (drain_q || (issued_active && (accept || timeout)));

      if (accept) begin
        tag_q      <= req_tag;
        addr_q     <= ifetch_req__address[31:2];
        mode_q     <= ifetch_req__mode;
        rtag_q     <= req_tag;
        wait_cnt_q <= '0;
        pend_q     <= 1'b0;
        if (!req_vld) begin
          state_q <= IDLE;
        end else if (!req_mem) begin
          state_q      <= LOCAL;
          resp_valid_q <= 1'b1;
          resp_debug_q <= ifetch_req__debug_fetch;
          resp_error_q <= !ifetch_req__debug_fetch;
          resp_mode_q  <= ifetch_req__mode;
          resp_tag_q   <= req_tag;
        end else begin
          state_q <= ACCESS;
          pend_q  <= !issue_new;
        end
      end else if (in_access) begin
        if (data_done) begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b1;
          resp_data_q  <= mem_read_data;
          resp_error_q <= mem_error;
          resp_mode_q  <= mode_q;
          resp_tag_q   <= rtag_q;
        end else if (timeout) begin
          state_q      <= IDLE;
          pend_q       <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_error_q <= 1'b1;
          resp_mode_q  <= mode_q;
          resp_tag_q   <= rtag_q;
        end
      end else if (state_q == LOCAL) begin
        state_q <= IDLE;
      end
    end
  end

  assign ifetch_resp__valid = resp_valid_q;
  assign ifetch_resp__debug = resp_debug_q;
  assign ifetch_resp__data  = resp_data_q;
  assign ifetch_resp__mode  = resp_mode_q;
  assign ifetch_resp__error = resp_error_q;
  assign ifetch_resp__tag   = resp_tag_q;

endmodule

// File: tb/tb_riscv_i32_ifetch_mem_adapter.sv
// Directed bench for riscv_i32_ifetch_mem_adapter with a wait-state SRAM model and a response scoreboard.
module tb_riscv_i32_ifetch_mem_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_pipeline;
  logic [2:0]  req_type;
  logic        debug_fetch;
  logic [31:0] address;
  logic [2:0]  mode;
  logic        resp_valid, resp_debug, resp_error;
  logic [31:0] resp_data;
  logic [2:0]  resp_mode;
  logic [1:0]  resp_tag;
  logic        mem_read_enable;
  logic [29:0] mem_address;
  logic [31:0] mem_read_data;
  logic        mem_wait, mem_error;

  riscv_i32_ifetch_mem_adapter dut (
    .clk(clk), .reset(reset),
    .ifetch_req__flush_pipeline(flush_pipeline), .ifetch_req__req_type(req_type),
    .ifetch_req__debug_fetch(debug_fetch), .ifetch_req__address(address),
    .ifetch_req__mode(mode), .ifetch_req__predicted_branch(1'b0),
    .ifetch_req__pc_if_mispredicted(32'h0),
    .ifetch_resp__valid(resp_valid), .ifetch_resp__debug(resp_debug),
    .ifetch_resp__data(resp_data), .ifetch_resp__mode(resp_mode),
    .ifetch_resp__error(resp_error), .ifetch_resp__tag(resp_tag),
    .mem_read_enable(mem_read_enable), .mem_address(mem_address),
    .mem_read_data(mem_read_data), .mem_wait(mem_wait), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        dbg;
    logic [2:0]  mode;
    logic [1:0]  tag;
    int          due;
  } exp_t;

  exp_t q[$];
  int checks = 0, passed = 0, fails = 0, cyc = 0;

  bit          m_busy = 0;
  int          m_left = 0;
  logic [29:0] m_addr = '0;
  int          wait_cfg = 0;
  bit          err_cfg = 0;

  function automatic logic [31:0] rom(input logic [29:0] a);
    case (a)
      30'd0:   return 32'h0000_0013;
      30'd1:   return 32'h0010_0093;
      30'd2:   return 32'h0020_0113;
      30'd4:   return 32'hDEAD_BEEF;
      default: return {a, 2'b11};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive_mem();
    mem_wait      = m_busy && (m_left > 0);
    mem_read_data = (m_busy && m_left == 0) ? rom(m_addr) : 32'h0;
    mem_error     = m_busy && (m_left == 0) && err_cfg;
  endtask

  task automatic push(input logic [31:0] d, input logic e, input logic g,
                      input logic [2:0] m, input logic [1:0] t, input int due);
    exp_t x;
    x.data = d; x.err = e; x.dbg = g; x.mode = m; x.tag = t; x.due = due;
    q.push_back(x);
  endtask

  task automatic tick();
    bit rd;
    logic [29:0] a;
    exp_t e;
    #1;
    rd = mem_read_enable;
    a  = mem_address;
    @(posedge clk);
    cyc++;
    #1;
    if (m_busy) begin
      if (!mem_wait) m_busy = 0;
      else m_left--;
    end
    if (rd) begin
      m_busy = 1; m_left = wait_cfg; m_addr = a;
    end
    drive_mem();
    if (resp_valid) begin
      if (q.size() == 0) begin
        check("resp_unexpected", {31'b0, resp_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        check("resp_cycle", cyc, e.due);
        check("resp_data", resp_data, e.data);
        check("resp_error", {31'b0, resp_error}, {31'b0, e.err});
        check("resp_debug", {31'b0, resp_debug}, {31'b0, e.dbg});
        check("resp_mode", {29'b0, resp_mode}, {29'b0, e.mode});
        check("resp_tag", {30'b0, resp_tag}, {30'b0, e.tag});
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      check("resp_missing", {31'b0, resp_valid}, 32'd1);
      void'(q.pop_front());
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic [2:0] m, input logic dbg, input logic fl);
    req_type = 3'd1; address = a; mode = m; debug_fetch = dbg; flush_pipeline = fl;
  endtask

  task automatic clear_req();
    req_type = 3'd0; flush_pipeline = 1'b0; debug_fetch = 1'b0;
  endtask

  task automatic pure_flush();
    req_type = 3'd0; flush_pipeline = 1'b1; debug_fetch = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_req();
    address = '0; mode = '0;
    drive_mem();

    // Reset state, with a request present that must not reach memory.
    fetch(32'h0, 3'd0, 1'b0, 1'b0);
    #3;
    check("rst_rd_en", {31'b0, mem_read_enable}, 32'd0);
    check("rst_mem_addr", {2'b0, mem_address}, 32'd0);
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_data", resp_data, 32'd0);
    check("rst_tag_err", {29'b0, resp_tag, resp_error}, 32'd0);
    clear_req();
    tick(); tick();
    reset = 1'b0;
    tick();

    // Sequential fetches, no wait states.
    for (int i = 0; i < 3; i++) begin
      fetch(32'(i * 4), 3'd3, 1'b0, 1'b0);
      #1;
      check("seq_rd_en", {31'b0, mem_read_enable}, 32'd1);
      check("seq_mem_addr", {2'b0, mem_address}, 32'(i));
      push(rom(30'(i)), 1'b0, 1'b0, 3'd3, 2'd0, cyc + 2);
      tick(); clear_req(); tick();
    end

    // Bus error is passed through with data.
    err_cfg = 1;
    fetch(32'hC, 3'd0, 1'b0, 1'b0);
    push(rom(30'd3), 1'b1, 1'b0, 3'd0, 2'd0, cyc + 2);
    tick(); clear_req(); tick();
    err_cfg = 0;

    // Three wait states.
    wait_cfg = 3;
    fetch(32'h10, 3'd1, 1'b0, 1'b0);
    push(32'hDEAD_BEEF, 1'b0, 1'b0, 3'd1, 2'd0, cyc + 5);
    tick(); clear_req();
    repeat (5) tick();

    // Timeout after WAIT_TIMEOUT wait cycles; the late data must not surface.
    wait_cfg = 15;
    fetch(32'h14, 3'd1, 1'b0, 1'b0);
    push(32'h0, 1'b1, 1'b0, 3'd1, 2'd0, cyc + 16);
    tick(); clear_req();
    repeat (17) tick();
    wait_cfg = 0;

    // Local faults, last in-window word, and debug fetches.
    fetch(32'h2, 3'd0, 1'b0, 1'b0);
    #1;
    check("misalign_rd_en", {31'b0, mem_read_enable}, 32'd0);
    push(32'h0, 1'b1, 1'b0, 3'd0, 2'd0, cyc + 1);
    tick(); clear_req(); tick();

    fetch(32'h0001_0000, 3'd0, 1'b0, 1'b0);
    #1;
    check("window_rd_en", {31'b0, mem_read_enable}, 32'd0);
    push(32'h0, 1'b1, 1'b0, 3'd0, 2'd0, cyc + 1);
    tick(); clear_req(); tick();

    fetch(32'h0000_FFFC, 3'd0, 1'b0, 1'b0);
    #1;
    check("edge_rd_en", {31'b0, mem_read_enable}, 32'd1);
    push(rom(30'h3FFF), 1'b0, 1'b0, 3'd0, 2'd0, cyc + 2);
    tick(); clear_req(); tick();

    fetch(32'h800, 3'd3, 1'b1, 1'b0);
    #1;
    check("debug_rd_en", {31'b0, mem_read_enable}, 32'd0);
    push(32'h0, 1'b0, 1'b1, 3'd3, 2'd0, cyc + 1);
    tick(); clear_req(); tick();

    fetch(32'h0002_0002, 3'd3, 1'b1, 1'b0);
    push(32'h0, 1'b0, 1'b1, 3'd3, 2'd0, cyc + 1);
    tick(); clear_req(); tick();

    // Flush a stalled fetch: new read waits for the old one to drain.
    wait_cfg = 1000;
    fetch(32'h20, 3'd0, 1'b0, 1'b0);
    tick(); clear_req(); tick(); tick();
    fetch(32'h100, 3'd2, 1'b0, 1'b1);
    #1;
    check("flush_rd_held", {31'b0, mem_read_enable}, 32'd0);
    push(rom(30'h40), 1'b0, 1'b0, 3'd2, 2'd1, cyc + 4);
    tick(); clear_req();
    m_left = 0;
    drive_mem();
    tick();
    wait_cfg = 0;
    #1;
    check("drained_rd_en", {31'b0, mem_read_enable}, 32'd1);
    check("drained_addr", {2'b0, mem_address}, 32'h40);
    tick(); tick();

    // Flush coinciding with completion suppresses the old response.
    fetch(32'h30, 3'd0, 1'b0, 1'b0);
    tick();
    pure_flush();
    tick(); clear_req(); tick(); tick();

    // Two more flushes wrap the generation back to 0.
    pure_flush(); tick(); clear_req();
    pure_flush(); tick(); clear_req();
    fetch(32'h6, 3'd4, 1'b0, 1'b0);
    push(32'h0, 1'b1, 1'b0, 3'd4, 2'd0, cyc + 1);
    tick(); clear_req(); tick();
    fetch(32'h800, 3'd3, 1'b1, 1'b1);
    push(32'h0, 1'b0, 1'b1, 3'd3, 2'd1, cyc + 1);
    tick(); clear_req(); tick();

    // Asynchronous reset clears a presented response immediately.
    fetch(32'h1, 3'd5, 1'b0, 1'b0);
    push(32'h0, 1'b1, 1'b0, 3'd5, 2'd1, cyc + 1);
    tick(); clear_req();
    reset = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, resp_valid}, 32'd0);
    check("async_rst_err_mode", {28'b0, resp_error, resp_mode}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Reset while a read is stalled: nothing is presented afterwards, tag restarts at 0.
    wait_cfg = 1000;
    fetch(32'h40, 3'd0, 1'b0, 1'b1);
    tick(); clear_req(); tick(); tick();
    reset = 1'b1;
    #1;
    check("inflight_rst_valid", {31'b0, resp_valid}, 32'd0);
    check("inflight_rst_rd_en", {31'b0, mem_read_enable}, 32'd0);
    m_busy = 0;
    drive_mem();
    tick(); tick();
    reset = 1'b0;
    wait_cfg = 0;
    repeat (3) tick();
    fetch(32'h8, 3'd0, 1'b0, 1'b0);
    push(rom(30'd2), 1'b0, 1'b0, 3'd0, 2'd0, cyc + 2);
    tick(); clear_req(); tick();

    repeat (3) tick();
    check("scoreboard_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
